// File: rtl/ecc_scalar_mult_ctrl.sv
// ============================================================================
// ecc_scalar_mult_ctrl : LSB-first double-and-add sequencer for k*P on secp256k1
// Revision: 1.0
// ============================================================================
`default_nettype none

module ecc_scalar_mult_ctrl #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_k,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             op_start,
  output logic             op_code,
  output logic [WIDTH-1:0] op_x1,
  output logic [WIDTH-1:0] op_y1,
  output logic [WIDTH-1:0] op_x2,
  output logic [WIDTH-1:0] op_y2,
  input  logic             op_done,
  input  logic [WIDTH-1:0] op_x3,
  input  logic [WIDTH-1:0] op_y3,
  input  logic             op_inf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_x,
  output logic [WIDTH-1:0] res_y,
  output logic             res_inf,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_ADD  = 3'd2,
    S_DBL  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] r_px;
  logic [WIDTH-1:0] r_py;
  logic [WIDTH-1:0] r_rx;
  logic [WIDTH-1:0] r_ry;
  logic             r_rinf;
  logic             r_op_start;
  logic             r_op_code;

  logic w_accept;
  logic w_k_last;
  logic w_op_done;

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_k_last  = ((r_k >> 1) == '0);
  // A done pulse coinciding with our own start pulse belongs to no operation of ours.
  assign w_op_done = op_done && !r_op_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_rx       <= '0;
      r_ry       <= '0;
      r_rinf     <= 1'b1;
      r_op_start <= 1'b0;
      r_op_code  <= 1'b0;
    end else begin
      r_op_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_k    <= in_k;
            r_px   <= in_x;
            r_py   <= in_y;
            r_rx   <= '0;
            r_ry   <= '0;
            r_rinf <= 1'b1;
            if ((in_x == '0) && (in_y == '0)) r_state <= S_DONE;
            else                              r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_k == '0) begin
            r_state <= S_DONE;
          end else if (r_k[0] && r_rinf) begin
            // First set bit: R = P without spending an engine operation.
            r_rx   <= r_px;
            r_ry   <= r_py;
            r_rinf <= 1'b0;
            if (w_k_last) begin
              r_state <= S_DONE;
            end else begin
              r_state    <= S_DBL;
              r_op_start <= 1'b1;
              r_op_code  <= 1'b0;
            end
          end else if (r_k[0]) begin
            r_state    <= S_ADD;
            r_op_start <= 1'b1;
            r_op_code  <= 1'b1;
          end else begin
            r_state    <= S_DBL;
            r_op_start <= 1'b1;
            r_op_code  <= 1'b0;
          end
        end
        S_ADD: begin
          if (w_op_done) begin
            r_rx   <= op_x3;
            r_ry   <= op_y3;
            r_rinf <= op_inf;
            if (w_k_last) begin
              r_state <= S_DONE;
            end else begin
              r_state    <= S_DBL;
              r_op_start <= 1'b1;
              r_op_code  <= 1'b0;
            end
          end
        end
        S_DBL: begin
          if (w_op_done) begin
            r_px <= op_x3;
            r_py <= op_y3;
            r_k  <= r_k >> 1;
            // Once P reaches infinity every later add is a no-op, so R is final.
            if (op_inf) r_state <= S_DONE;
            else        r_state <= S_SCAN;
          end
        end
        S_DONE: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign op_start  = r_op_start;
  assign op_code   = r_op_code;
  assign op_x1     = r_px;
  assign op_y1     = r_py;
  assign op_x2     = r_rx;
  assign op_y2     = r_ry;
  assign res_valid = (r_state == S_DONE);
  assign res_inf   = (r_state == S_DONE) && r_rinf;
  assign res_x     = ((r_state == S_DONE) && !r_rinf) ? r_rx : '0;
  assign res_y     = ((r_state == S_DONE) && !r_rinf) ? r_ry : '0;

endmodule

`default_nettype wire

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// ============================================================================
// tb_ecc_scalar_mult_ctrl : scoreboard bench with a 3-cycle affine point engine model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ecc_scalar_mult_ctrl;

  typedef logic [255:0] u256;
  typedef struct packed { logic inf; u256 x; u256 y; } pt_t;
  typedef struct { pt_t res; int n_add; int n_dbl; int lat; } exp_t;

  localparam u256 PM  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam u256 GX  = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam u256 GY  = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, op_start, op_code, op_done, op_inf;
  logic res_valid, res_ready = 1'b0, res_inf, busy;
  u256  in_k = '0, in_x = '0, in_y = '0;
  u256  op_x1, op_y1, op_x2, op_y2, op_x3, op_y3, res_x, res_y;

  int   n_tests = 0, n_fail = 0;
  int   n_add = 0, n_dbl = 0;
  logic force_inf_add = 1'b0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ecc_scalar_mult_ctrl #(.WIDTH(256)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_k(in_k), .in_x(in_x), .in_y(in_y), .op_start(op_start), .op_code(op_code),
    .op_x1(op_x1), .op_y1(op_y1), .op_x2(op_x2), .op_y2(op_y2), .op_done(op_done),
    .op_x3(op_x3), .op_y3(op_y3), .op_inf(op_inf), .res_valid(res_valid),
    .res_ready(res_ready), .res_x(res_x), .res_y(res_y), .res_inf(res_inf), .busy(busy)
  );

  task automatic check(input string tag, input u256 got, input u256 exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- field and curve model ----------------
  function automatic u256 fmul(input u256 a, input u256 b);
    logic [511:0] t;
    t = {256'd0, a} * {256'd0, b};
    // 2^256 == 2^32 + 977 (mod p)
    while (t[511:256] != '0)
      t = {256'd0, t[255:0]} + {256'd0, t[511:256]} * 512'h1000003D1;
    if (t[255:0] >= PM) t[255:0] = t[255:0] - PM;
    return t[255:0];
  endfunction

  function automatic u256 fadd(input u256 a, input u256 b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, PM}) s = s - {1'b0, PM};
    return s[255:0];
  endfunction

  function automatic u256 fsub(input u256 a, input u256 b);
    return (a >= b) ? (a - b) : (a + (PM - b));
  endfunction

  function automatic u256 finv(input u256 a);
    u256 r, e;
    r = 256'd1;
    e = PM - 256'd2;
    for (int i = 255; i >= 0; i--) begin
      r = fmul(r, r);
      if (e[i]) r = fmul(r, a);
    end
    return r;
  endfunction

  function automatic pt_t mkpt(input logic inf, input u256 x, input u256 y);
    pt_t p;
    p.inf = inf; p.x = x; p.y = y;
    return p;
  endfunction

  function automatic pt_t pdbl(input pt_t p);
    u256 lam, x3;
    if (p.inf || p.y == '0) return mkpt(1'b1, '0, '0);
    lam = fmul(fmul(256'd3, fmul(p.x, p.x)), finv(fadd(p.y, p.y)));
    x3  = fsub(fmul(lam, lam), fadd(p.x, p.x));
    return mkpt(1'b0, x3, fsub(fmul(lam, fsub(p.x, x3)), p.y));
  endfunction

  function automatic pt_t padd(input pt_t a, input pt_t b);
    u256 lam, x3;
    if (a.inf) return b;
    if (b.inf) return a;
    if (a.x == b.x) return (a.y == b.y) ? pdbl(a) : mkpt(1'b1, '0, '0);
    lam = fmul(fsub(b.y, a.y), finv(fsub(b.x, a.x)));
    x3  = fsub(fsub(fmul(lam, lam), a.x), b.x);
    return mkpt(1'b0, x3, fsub(fmul(lam, fsub(a.x, x3)), a.y));
  endfunction

  // Golden multiply is MSB-first, independent of the DUT's scan order.
  function automatic pt_t smul(input u256 k, input pt_t p);
    pt_t r;
    r = mkpt(1'b1, '0, '0);
    for (int i = 255; i >= 0; i--) begin
      r = pdbl(r);
      if (k[i]) r = padd(r, p);
    end
    return r;
  endfunction

  // ---------------- point engine model ----------------
  initial begin : engine
    int  cnt;
    pt_t res;
    u256 cx1, cy1, cx2, cy2;
    cnt = 0;
    op_done = 1'b0; op_inf = 1'b0; op_x3 = '0; op_y3 = '0;
    forever begin
      @(posedge clk); #1;
      op_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (busy) begin
            check("op_x1_stable", op_x1, cx1);
            check("op_x2_stable", op_x2, cx2);
          end
          op_x3 = res.x; op_y3 = res.y; op_inf = res.inf; op_done = 1'b1;
        end
      end
      if (op_start) begin
        cnt = 3;
        cx1 = op_x1; cy1 = op_y1; cx2 = op_x2; cy2 = op_y2;
        if (op_code) begin
          n_add++;
          res = force_inf_add ? mkpt(1'b1, '0, '0)
                              : padd(mkpt(1'b0, cx1, cy1), mkpt(1'b0, cx2, cy2));
        end else begin
          n_dbl++;
          res = pdbl(mkpt(1'b0, cx1, cy1));
        end
      end
    end
  end

  // ---------------- job driver / scoreboard ----------------
  task automatic run_job(input u256 k, input pt_t p, input pt_t golden, input int lat, input int hold);
    exp_t e;
    int   cyc, msb;
    e.res = golden;
    e.lat = lat;
    msb = 0;
    for (int i = 0; i < 256; i++) if (k[i]) msb = i;
    if (p.inf || k == '0) begin
      e.n_add = 0; e.n_dbl = 0;
    end else begin
      e.n_add = $countones(k) - 1; e.n_dbl = msb;
    end
    sb_q.push_back(e);

    in_k = k; in_x = p.x; in_y = p.y; in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    if (!in_ready) begin
      check("accept_timeout", {255'd0, in_ready}, 256'd1);
      in_valid = 1'b0;
      void'(sb_q.pop_front());
      return;
    end
    n_add = 0; n_dbl = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!res_valid && cyc < 5000) begin @(posedge clk); #1; cyc++; end
    e = sb_q.pop_front();
    if (!res_valid) begin
      check("res_timeout", {255'd0, res_valid}, 256'd1);
      return;
    end
    if (e.lat >= 0) check("latency", cyc, e.lat);
    check("res_inf", {255'd0, res_inf}, {255'd0, e.res.inf});
    check("res_x", res_x, e.res.x);
    check("res_y", res_y, e.res.y);
    check("n_add", n_add, e.n_add);
    check("n_dbl", n_dbl, e.n_dbl);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {255'd0, res_valid}, 256'd1);
      check("hold_x", res_x, e.res.x);
      check("hold_in_ready", {255'd0, in_ready}, 256'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("post_in_ready", {255'd0, in_ready}, 256'd1);
    check("post_res_valid", {255'd0, res_valid}, 256'd0);
  endtask

  initial begin : main
    pt_t g, inf_pt;
    u256 k;
    int  starts, cyc;
    g      = mkpt(1'b0, GX, GY);
    inf_pt = mkpt(1'b1, '0, '0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {255'd0, in_ready}, 256'd1);
    check("rst_busy", {255'd0, busy}, 256'd0);
    check("rst_res_valid", {255'd0, res_valid}, 256'd0);
    check("rst_op_start", {255'd0, op_start}, 256'd0);
    check("rst_op_x1", op_x1, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_job(256'd0, g, inf_pt, 2, 0);
    run_job(256'd1, g, g, 2, 0);
    run_job(256'd5, inf_pt, inf_pt, 1, 0);
    run_job(256'd3, g, smul(256'd3, g), -1, 10);
    k = {1'b1, 254'd0, 1'b1};
    run_job(k, g, smul(k, g), -1, 0);
    for (int i = 0; i < 5; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_job(k, g, smul(k, g), -1, 0);
    end

    force_inf_add = 1'b1;
    run_job(256'd3, g, inf_pt, -1, 0);
    force_inf_add = 1'b0;

    // Abort mid-ADD: reset one cycle after the ADD start, let the stale done arrive.
    in_k = 256'd3; in_x = GX; in_y = GY; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!(op_start && op_code) && cyc < 100) begin @(posedge clk); #1; cyc++; end
    check("abort_add_seen", {255'd0, op_start & op_code}, 256'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    starts = n_add + n_dbl;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_in_ready", {255'd0, in_ready}, 256'd1);
    check("abort_busy", {255'd0, busy}, 256'd0);
    check("abort_res_valid", {255'd0, res_valid}, 256'd0);
    check("abort_no_start", n_add + n_dbl, starts);

    run_job(256'd3, g, smul(256'd3, g), -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
